// File: rtl/ksa_pkg.sv
// ksa_pkg: shared definitions for the word-serial Kogge-Stone add scheduler.
//   ksa_state_t - scheduler FSM states
//   KSA_W       - limb width of the shared ksa64x64 adder
//   KSA_CIN_W   - width of the ksa64x64 carry-in port
package ksa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ksa_state_t;

  localparam int KSA_W     = 64;
  localparam int KSA_CIN_W = 32;

endpackage

// File: rtl/ksa64x64.sv
// ksa64x64: combinational 64-bit Kogge-Stone adder, shared datapath element.
//   x, y  in  64  addends
//   cin   in  32  carry-in; any non-zero value counts as a carry of one
//   sum   out 64  x + y + carry-in, modulo 2^64
//   cout  out 1   carry out of bit 63
module ksa64x64
  import ksa_pkg::*;
(
  input  logic [KSA_W-1:0]     x,
  input  logic [KSA_W-1:0]     y,
  input  logic [KSA_CIN_W-1:0] cin,
  output logic [KSA_W-1:0]     sum,
  output logic                 cout
);

  logic             c0_s;
  logic [KSA_W-1:0] p0_s;
  logic [KSA_W-1:0] g_s;
  logic [KSA_W-1:0] p_s;
  logic [KSA_W-1:0] gn_s;
  logic [KSA_W-1:0] pn_s;
  logic [KSA_W:0]   c_s;

  assign c0_s = (cin != {KSA_CIN_W{1'b0}});

  // Log-depth parallel-prefix tree, then per-bit carries folding in carry-in.
  always_comb begin
    p0_s = x ^ y;
    g_s  = x & y;
    p_s  = p0_s;
    gn_s = g_s;
    pn_s = p_s;
    for (int l = 0; l < 6; l++) begin
      for (int i = 0; i < KSA_W; i++) begin
        if (i >= (1 << l)) begin
          gn_s[i] = g_s[i] | (p_s[i] & g_s[i - (1 << l)]);
          pn_s[i] = p_s[i] & p_s[i - (1 << l)];
        end else begin
          gn_s[i] = g_s[i];
          pn_s[i] = p_s[i];
        end
      end
      g_s = gn_s;
      p_s = pn_s;
    end
    c_s[0] = c0_s;
    for (int i = 0; i < KSA_W; i++) begin
      c_s[i + 1] = g_s[i] | (p_s[i] & c0_s);
    end
  end

  assign sum  = p0_s ^ c_s[KSA_W-1:0];
  assign cout = c_s[KSA_W];

endmodule

// File: rtl/ksa_rr_arb2.sv
// ksa_rr_arb2: two-way round-robin grant with a one-bit priority register.
//   clk, rst    clock, synchronous active-high reset (prio -> 0, req0 favoured)
//   en          grants may be issued this cycle
//   req0, req1  requests
//   gnt0, gnt1  combinational grants, at most one high; a grant is a handshake
module ksa_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic prio_r;

  assign gnt0 = en & req0 & (~req1 | ~prio_r);
  assign gnt1 = en & req1 & (~req0 |  prio_r);

  // Priority flips to the loser of each grant so contention strictly alternates.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= 1'b0;
    end else if (gnt0 | gnt1) begin
      prio_r <= gnt0;
    end
  end

endmodule

// File: rtl/ksa_add_sched.sv
// ksa_add_sched: shares one ksa64x64 between two requesters of WORDS-limb adds.
// Arbitrates round-robin, adds one limb per cycle LSB-first with chained carry,
// and returns the wide sum over a valid/ready response port.
//   clk, rst                  clock, synchronous active-high reset
//   req{0,1}_valid/_ready     request handshake (ready combinational, IDLE only)
//   req{0,1}_a/_b/_cin        wide operands and carry-in
//   rsp_valid/rsp_ready       response handshake
//   rsp_sum/rsp_cout/rsp_id   wide sum, top-limb carry-out, owning requester
//   busy                      operation in flight (RUN or DONE)
module ksa_add_sched
  import ksa_pkg::*;
#(
  parameter int W     = KSA_W,
  parameter int WORDS = 4,
  parameter int CW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [W*WORDS-1:0]   req0_a,
  input  logic [W*WORDS-1:0]   req0_b,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [W*WORDS-1:0]   req1_a,
  input  logic [W*WORDS-1:0]   req1_b,
  input  logic                 req1_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W*WORDS-1:0]   rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_id,
  output logic                 busy
);

  ksa_state_t             state_r;
  ksa_state_t             state_s;
  logic [CW-1:0]          idx_r;
  logic                   carry_r;
  logic [W*WORDS-1:0]     opa_r;
  logic [W*WORDS-1:0]     opb_r;
  logic [W*WORDS-1:0]     sum_r;
  logic                   cout_r;
  logic                   id_r;
  logic                   gnt0_s;
  logic                   gnt1_s;
  logic                   hs_s;
  logic                   last_s;
  logic [W-1:0]           x_s;
  logic [W-1:0]           y_s;
  logic [KSA_CIN_W-1:0]   add_cin_s;
  logic [W-1:0]           add_sum_s;
  logic                   add_cout_s;

  // Grants are suppressed during reset so ready is never seen high then.
  ksa_rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   ((state_r == IDLE) & ~rst),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .gnt0 (gnt0_s),
    .gnt1 (gnt1_s)
  );

  assign hs_s      = gnt0_s | gnt1_s;
  assign last_s    = (idx_r == CW'(WORDS - 1));
  assign x_s       = opa_r[idx_r*W +: W];
  assign y_s       = opb_r[idx_r*W +: W];
  assign add_cin_s = {{(KSA_CIN_W-1){1'b0}}, carry_r};

  ksa64x64 u_add (
    .x    (x_s),
    .y    (y_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = hs_s ? RUN : IDLE;
      RUN:     state_s = last_s ? DONE : RUN;
      DONE:    state_s = rsp_ready ? IDLE : DONE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, limb-serial accumulation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
      opa_r   <= {(W*WORDS){1'b0}};
      opb_r   <= {(W*WORDS){1'b0}};
      sum_r   <= {(W*WORDS){1'b0}};
      cout_r  <= 1'b0;
      id_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            opa_r   <= gnt1_s ? req1_a   : req0_a;
            opb_r   <= gnt1_s ? req1_b   : req0_b;
            carry_r <= gnt1_s ? req1_cin : req0_cin;
            id_r    <= gnt1_s;
            idx_r   <= {CW{1'b0}};
          end
        end
        RUN: begin
          sum_r[idx_r*W +: W] <= add_sum_s;
          carry_r             <= add_cout_s;
          idx_r               <= idx_r + CW'(1);
          if (last_s) begin
            cout_r <= add_cout_s;
          end
        end
        DONE: begin
          // Result held until the consumer takes it.
        end
        default: begin
        end
      endcase
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign rsp_valid  = (state_r == DONE);
  assign busy       = (state_r != IDLE);
  assign rsp_sum    = sum_r;
  assign rsp_cout   = cout_r;
  assign rsp_id     = id_r;

endmodule

// File: tb/tb_ksa_add_sched.sv
// tb_ksa_add_sched: directed self-checking bench for ksa_add_sched (WORDS=4).
module tb_ksa_add_sched;

  localparam int WORDS = 4;
  localparam int WW    = 64 * WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [WW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          req0_cin, req1_cin;
  logic          rsp_valid, rsp_ready;
  logic [WW-1:0] rsp_sum;
  logic          rsp_cout, rsp_id, busy;

  int checks   = 0;
  int failures = 0;
  int n;

  logic [WW-1:0] ones;
  logic [WW-1:0] eab;
  logic [WW-1:0] t2_sum;
  logic [WW-1:0] hold_sum;

  always #5 clk = ~clk;

  ksa_add_sched #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until rsp_valid, bounded.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ones = {WW{1'b1}};
    eab  = {4{64'hEEAAAABBEEAAAABB}};
    t2_sum = {{3{64'hDD555577DD555577}}, 64'hDD555577DD555576};
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = {WW{1'b0}}; req0_b = {WW{1'b0}}; req0_cin = 1'b0;
    req1_a = {WW{1'b0}}; req1_b = {WW{1'b0}}; req1_cin = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();

    // Reset: outputs quiet, ready low even with a valid request.
    req0_valid = 1'b1;
    #1;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", rsp_sum, {WW{1'b0}});
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Test 1: all-ones + 1 wraps to zero with carry-out.
    req0_a = ones; req0_b = {{(WW-1){1'b0}}, 1'b1}; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    chk("t1_ready0", req0_ready, 1'b1);
    chk("t1_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    chk("t1_busy", busy, 1'b1);
    wait_valid(n);
    chk("t1_latency", n, 4);
    chk("t1_sum", rsp_sum, {WW{1'b0}});
    chk("t1_cout", rsp_cout, 1'b1);
    chk("t1_id", rsp_id, 1'b0);
    release_rsp();
    chk("t1_idle_valid", rsp_valid, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);

    // Test 2: requester 1, carry ripples through every limb.
    req1_a = eab; req1_b = eab; req1_cin = 1'b0; req1_valid = 1'b1;
    #1;
    chk("t2_ready1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    wait_valid(n);
    chk("t2_latency", n, 4);
    chk("t2_sum", rsp_sum, t2_sum);
    chk("t2_cout", rsp_cout, 1'b1);
    chk("t2_id", rsp_id, 1'b1);
    release_rsp();

    // Test 3: contention after reset alternates req0, req1, req0.
    do_reset();
    req0_a = {WW{1'b0}}; req0_b = {WW{1'b0}}; req0_cin = 1'b1;
    req1_a = {WW{1'b0}}; req1_b = {WW{1'b0}}; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t3a_ready0", req0_ready, 1'b1);
    chk("t3a_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t3a_busy_ready1", req1_ready, 1'b0);
    wait_valid(n);
    chk("t3a_sum", rsp_sum, {{(WW-1){1'b0}}, 1'b1});
    chk("t3a_cout", rsp_cout, 1'b0);
    chk("t3a_id", rsp_id, 1'b0);
    release_rsp();
    req0_valid = 1'b1;
    #1;
    chk("t3b_ready1", req1_ready, 1'b1);
    chk("t3b_ready0", req0_ready, 1'b0);
    tick();
    req1_valid = 1'b0;
    wait_valid(n);
    chk("t3b_sum", rsp_sum, {{(WW-1){1'b0}}, 1'b1});
    chk("t3b_id", rsp_id, 1'b1);
    release_rsp();
    req1_valid = 1'b1;
    #1;
    chk("t3c_ready0", req0_ready, 1'b1);
    chk("t3c_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_valid(n);
    chk("t3c_id", rsp_id, 1'b0);
    release_rsp();

    // Test 4: backpressure holds DONE; one bubble before the next grant.
    req0_a = {{(WW-3){1'b0}}, 3'd5}; req0_b = {{(WW-3){1'b0}}, 3'd7}; req0_cin = 1'b0;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    wait_valid(n);
    chk("t4_latency", n, 4);
    hold_sum = {{(WW-4){1'b0}}, 4'd12};
    req1_a = {{(WW-4){1'b0}}, 4'd9}; req1_b = {{(WW-4){1'b0}}, 4'd6}; req1_cin = 1'b0;
    req1_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_valid", rsp_valid, 1'b1);
      chk("t4_hold_sum", rsp_sum, hold_sum);
      chk("t4_hold_id", rsp_id, 1'b0);
      chk("t4_hold_ready0", req0_ready, 1'b0);
      chk("t4_hold_ready1", req1_ready, 1'b0);
      chk("t4_hold_busy", busy, 1'b1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_bubble_ready1", req1_ready, 1'b0);
    tick();
    rsp_ready = 1'b0;
    chk("t4_idle_valid", rsp_valid, 1'b0);
    chk("t4_reassert_ready1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    wait_valid(n);
    chk("t4b_sum", rsp_sum, {{(WW-4){1'b0}}, 4'd15});
    chk("t4b_id", rsp_id, 1'b1);
    release_rsp();

    // Test 5: reset while idx==2 drops the operation and restores prio=0.
    req0_a = {{(WW-5){1'b0}}, 5'd10}; req0_b = {{(WW-5){1'b0}}, 5'd20}; req0_cin = 1'b0;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", rsp_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    req1_a = {{(WW-2){1'b0}}, 2'd3}; req1_b = {{(WW-3){1'b0}}, 3'd5}; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t5_prio_ready0", req0_ready, 1'b1);
    chk("t5_prio_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0;
    #1;
    chk("t5_ready1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    wait_valid(n);
    chk("t5_latency", n, 4);
    chk("t5_sum", rsp_sum, {{(WW-4){1'b0}}, 4'd9});
    chk("t5_cout", rsp_cout, 1'b0);
    chk("t5_id", rsp_id, 1'b1);
    release_rsp();

    // Test 6: max + max + 1 = max with carry-out.
    req0_a = ones; req0_b = ones; req0_cin = 1'b1; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    wait_valid(n);
    chk("t6_sum", rsp_sum, ones);
    chk("t6_cout", rsp_cout, 1'b1);
    chk("t6_id", rsp_id, 1'b0);
    release_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
